ascon_round_seq_ti: RTL and testbench
=====================================

ASCON_ROUND_SEQ_TI -- requirements
Module: ascon_round_seq_ti

Interface
REQ-001 SHALL have parameter CTR_W, 5, width of ctr and rounds ports.
REQ-002 SHALL have parameter SEED_DEFAULT, 64'h0123_4567_89AB_CDEF, PRNG seed used at reset and for zero seeds.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  request a permutation run; sampled only in IDLE.
REQ-006 SHALL have port rounds_in  in  CTR_W  requested round count (6, 8, 12; other = 1-round test mode).
REQ-007 SHALL have port step  in  1  datapath consumed current round; advance.
REQ-008 SHALL have port seed_load  in  1  reseed PRNG; honoured only in IDLE.
REQ-009 SHALL have port seed  in  64  reseed value.
REQ-010 SHALL have ports rounds  out  CTR_W, ctr  out  CTR_W  latched round count and current round index (1-based) for the share-wise constant adders.
REQ-011 SHALL have ports r0, r1  out  64 each  fresh masks for shares 0/1/2 constant addition.
REQ-012 SHALL have ports rc  out  8, round_valid  out  1, busy  out  1, done  out  1.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE: start=1 latches rounds_in into rounds; next cycle RUN, ctr=1, round_valid=1, busy=1.
REQ-015 Round count N SHALL be 6, 8, 12 for those rounds values, else 1.
REQ-016 RUN: step=1 and ctr<N -> ctr+1; step=1 and ctr==N -> DONE; step=0 -> all outputs hold (stall, any length).
REQ-017 DONE: done=1 for exactly one cycle, round_valid=0, busy=1; then IDLE with ctr=0, busy=0.
REQ-018 start in RUN or DONE SHALL be ignored (no relatch, no restart).
REQ-019 rc SHALL equal (S - (ctr-1)*15) mod 256, S=0x96/0xB4/0xF0/0x4B for 6/8/12/other; rc=0 when round_valid=0; final round always 0x4B.
REQ-020 Two independent 64-bit xorshift PRNGs (x^=x<<13; x^=x>>7; x^=x<<17) SHALL drive r0 (state A) and r1 (state B).
REQ-021 Both PRNGs SHALL advance once on the start-accept cycle and once per RUN cycle with step=1; otherwise hold.
REQ-022 seed_load in IDLE: A<=seed, B<=seed ^ 64'hA5A5_A5A5_A5A5_A5A5; seed==0 SHALL substitute SEED_DEFAULT; seed_load with start same cycle: reseed first, start also accepted, PRNGs advance from new seed.
REQ-023 r0/r1 SHALL never be all-zero while TI_RANDOM_EN defined.

Reset
REQ-024 rst=1 SHALL force IDLE from any state, including mid-run, next edge.
REQ-025 Reset values: ctr=0, rounds=0, rc=0, round_valid=0, busy=0, done=0; A=SEED_DEFAULT, B=SEED_DEFAULT ^ 64'hA5A5_A5A5_A5A5_A5A5.
REQ-026 rst SHALL dominate start, step and seed_load in the same cycle.

Configuration
REQ-027 Macro ASCON_TI_RANDOM_EN defined: r0/r1 from PRNGs per REQ-020..023.
REQ-028 Macro undefined: PRNGs not instantiated, r0=r1=0 constantly, seed_load ignored; FSM, ctr, rc unchanged (unmasked debug).

Structure
REQ-029 Package ascon_ti_pkg SHALL hold FSM state enum, start constants 0x96/0xB4/0xF0/0x4B, step 15, reseed XOR constant, SEED_DEFAULT value.
REQ-030 Sub-module ti_xorshift64 (load, seed, adv, state) SHALL be instantiated twice.

Verification
REQ-031 rounds_in=12, start, step=1 constant -> ctr 1..12 over 12 cycles, rc F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B; done next cycle.
REQ-032 rounds_in=6 and 8 -> rc starts 0x96 / 0xB4, ends 0x4B; rounds_in=3 -> single round rc=0x4B.
REQ-033 step low 5 cycles at ctr=4 -> ctr, rc, r0, r1 frozen; resume identical to unstalled run.
REQ-034 start pulsed at ctr=7 -> ignored, run completes at 12; rst at ctr=5 -> next cycle IDLE, all outputs 0.
REQ-035 seed_load seed=0 -> same r0/r1 sequence as post-reset; seed=1 -> first r0=xorshift(1)=0x0000_0000_4082_2041.
REQ-036 Build without ASCON_TI_RANDOM_EN -> r0=r1=0 all cycles, ctr/rc sequences as REQ-031.

Source files
------------

// File: rtl/ascon_ti_pkg.sv
// Shared types and constants for the threshold-implementation Ascon round sequencer.
package ascon_ti_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Round-constant start values per round count; every schedule ends on 0x4B.
  localparam logic [7:0] RcStart6  = 8'h96;
  localparam logic [7:0] RcStart8  = 8'hB4;
  localparam logic [7:0] RcStart12 = 8'hF0;
  localparam logic [7:0] RcStart1  = 8'h4B;
  localparam logic [7:0] RcStep    = 8'd15;

  localparam logic [63:0] ReseedXor   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] SeedDefault = 64'h0123_4567_89AB_CDEF;

  // Number of rounds for a requested count; unsupported values fall back to one test round.
  function automatic int unsigned round_count(input int unsigned r);
    case (r)
      6:       return 6;
      8:       return 8;
      12:      return 12;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] rc_start(input int unsigned r);
    case (r)
      6:       return RcStart6;
      8:       return RcStart8;
      12:      return RcStart12;
      default: return RcStart1;
    endcase
  endfunction

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/ti_xorshift64.sv
// 64-bit xorshift mask generator with load and advance controls.
// A zero load value is replaced by RESET_VAL so the state can never lock at zero.
module ti_xorshift64
  import ascon_ti_pkg::*;
#(
  parameter logic [63:0] RESET_VAL = SeedDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        adv,
  output logic [63:0] state
);

  logic [63:0] base;
  logic [63:0] state_d;

  // Reseed takes effect before the advance, so load+adv steps from the new seed.
  always_comb begin
    base    = state;
    if (load) begin
      base = (seed == 64'd0) ? RESET_VAL : seed;
    end
    state_d = adv ? xorshift64(base) : base;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_VAL;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/ascon_round_seq_ti.sv
// Round sequencer for a masked Ascon permutation: walks the round index, produces the
// round constant and supplies fresh masks r0/r1 for share-wise constant addition.
// Build option: define ASCON_TI_RANDOM_EN to enable the mask PRNGs; without it r0/r1
// are tied to zero and seed_load is ignored (unmasked debug build).
module ascon_round_seq_ti
  import ascon_ti_pkg::*;
#(
  parameter int unsigned CTR_W        = 5,
  parameter logic [63:0] SEED_DEFAULT = SeedDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CTR_W-1:0] rounds_in,
  input  logic             step,
  input  logic             seed_load,
  input  logic [63:0]      seed,
  output logic [CTR_W-1:0] rounds,
  output logic [CTR_W-1:0] ctr,
  output logic [63:0]      r0,
  output logic [63:0]      r1,
  output logic [7:0]       rc,
  output logic             round_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CTR_W-1:0] n_rounds;

  assign n_rounds = CTR_W'(round_count(32'(rounds)));

  // Sequencer FSM; all outputs are registered and hold while step is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rounds      <= '0;
      ctr         <= '0;
      rc          <= '0;
      round_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StRun;
            rounds      <= rounds_in;
            ctr         <= CTR_W'(1);
            rc          <= rc_start(32'(rounds_in));
            round_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StRun: begin
          if (step) begin
            if (ctr == n_rounds) begin
              state_q     <= StDone;
              rc          <= '0;
              round_valid <= 1'b0;
              done        <= 1'b1;
            end else begin
              ctr <= ctr + CTR_W'(1);
              rc  <= rc - RcStep;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ctr     <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ASCON_TI_RANDOM_EN
  logic        prng_load;
  logic        prng_adv;
  logic [63:0] seed_a;
  logic [63:0] seed_b;

  // Masks advance on start acceptance and on every consumed round.
  always_comb begin
    prng_load = seed_load && (state_q == StIdle);
    prng_adv  = ((state_q == StIdle) && start) || ((state_q == StRun) && step);
    seed_a    = (seed == 64'd0) ? SEED_DEFAULT : seed;
    seed_b    = seed_a ^ ReseedXor;
  end

  ti_xorshift64 #(
    .RESET_VAL(SEED_DEFAULT)
  ) u_prng_a (
    .clk  (clk),
    .rst  (rst),
    .load (prng_load),
    .seed (seed_a),
    .adv  (prng_adv),
    .state(r0)
  );

  ti_xorshift64 #(
    .RESET_VAL(SEED_DEFAULT ^ ReseedXor)
  ) u_prng_b (
    .clk  (clk),
    .rst  (rst),
    .load (prng_load),
    .seed (seed_b),
    .adv  (prng_adv),
    .state(r1)
  );
`else
  logic unused_cfg;

  assign r0         = '0;
  assign r1         = '0;
  assign unused_cfg = ^{seed_load, seed, SEED_DEFAULT};
`endif

endmodule

// File: tb/tb_ascon_round_seq_ti.sv
// Self-checking bench for ascon_round_seq_ti: a cycle-level behavioural model checked
// every cycle, plus directed runs with literal expectations.
module tb_ascon_round_seq_ti;

  localparam logic [63:0] SD  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] MIX = 64'hA5A5_A5A5_A5A5_A5A5;
`ifdef ASCON_TI_RANDOM_EN
  localparam logic [63:0] ExpR0Reset = SD;
  localparam logic [63:0] ExpR1Reset = 64'hA486_E0C2_2C0E_684A;
  localparam logic [63:0] ExpR0Seed1 = 64'h0000_0000_4082_2041;
`else
  localparam logic [63:0] ExpR0Reset = 64'd0;
  localparam logic [63:0] ExpR1Reset = 64'd0;
  localparam logic [63:0] ExpR0Seed1 = 64'd0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  rounds_in;
  logic        step;
  logic        seed_load;
  logic [63:0] seed;
  logic [4:0]  rounds;
  logic [4:0]  ctr;
  logic [63:0] r0;
  logic [63:0] r1;
  logic [7:0]  rc;
  logic        round_valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  logic [7:0] lit12 [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                             8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  ascon_round_seq_ti #(
    .CTR_W       (5),
    .SEED_DEFAULT(SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rounds_in  (rounds_in),
    .step       (step),
    .seed_load  (seed_load),
    .seed       (seed),
    .rounds     (rounds),
    .ctr        (ctr),
    .r0         (r0),
    .r1         (r1),
    .rc         (rc),
    .round_valid(round_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    return t ^ (t << 17);
  endfunction

  function automatic int n_of(input int r);
    return (r == 6 || r == 8 || r == 12) ? r : 1;
  endfunction

  function automatic int s_of(input int r);
    return (r == 6) ? 'h96 : (r == 8) ? 'hB4 : (r == 12) ? 'hF0 : 'h4B;
  endfunction

  int          m_phase;  // 0 idle, 1 running, 2 done
  int          m_ctr;
  int          m_rounds;
  logic [63:0] m_a;
  logic [63:0] m_b;

  always @(posedge clk) begin : model
    logic [63:0] na, nb, s;
    if (rst) begin
      m_phase  <= 0;
      m_ctr    <= 0;
      m_rounds <= 0;
      m_a      <= SD;
      m_b      <= SD ^ MIX;
    end else if (m_phase == 0) begin
      na = m_a;
      nb = m_b;
      if (seed_load) begin
        s  = (seed == 64'd0) ? SD : seed;
        na = s;
        nb = s ^ MIX;
        if (nb == 64'd0) nb = SD ^ MIX;
      end
      if (start) begin
        na       = xs(na);
        nb       = xs(nb);
        m_phase  <= 1;
        m_ctr    <= 1;
        m_rounds <= int'(rounds_in);
      end
      m_a <= na;
      m_b <= nb;
    end else if (m_phase == 1) begin
      if (step) begin
        m_a <= xs(m_a);
        m_b <= xs(m_b);
        if (m_ctr == n_of(m_rounds)) m_phase <= 2;
        else m_ctr <= m_ctr + 1;
      end
    end else begin
      m_phase <= 0;
      m_ctr   <= 0;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_phase != 2) check("model_ctr", 64'(ctr), 64'(m_ctr));
      check("model_rounds", 64'(rounds), 64'(m_rounds));
      check("model_rc", 64'(rc),
            (m_phase == 1) ? 64'((s_of(m_rounds) - (m_ctr - 1) * 15) & 255) : 64'd0);
      check("model_valid", 64'(round_valid), 64'(m_phase == 1));
      check("model_busy", 64'(busy), 64'(m_phase != 0));
      check("model_done", 64'(done), 64'(m_phase == 2));
`ifdef ASCON_TI_RANDOM_EN
      check("model_r0", r0, m_a);
      check("model_r1", r1, m_b);
`else
      check("model_r0", r0, 64'd0);
      check("model_r1", r1, 64'd0);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_run(input logic [4:0] r, input int n, input logic [7:0] first);
    rounds_in = r;
    start     = 1'b1;
    step      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("run_ctr", 64'(ctr), 64'(i + 1));
      if (i == 0) check("run_rc_first", 64'(rc), 64'(first));
      if (i == n - 1) check("run_rc_last", 64'(rc), 64'h4B);
      if (r == 5'd12) check("run_rc12", 64'(rc), 64'(lit12[i]));
      if (i < n - 1) @(negedge clk);
    end
    @(negedge clk);
    check("run_done", 64'(done), 64'd1);
    check("run_valid_off", 64'(round_valid), 64'd0);
    step = 1'b0;
    @(negedge clk);
    check("run_idle_busy", 64'(busy), 64'd0);
    check("run_idle_ctr", 64'(ctr), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rounds_in = '0;
    step      = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ctr", 64'(ctr), 64'd0);
    check("reset_rc", 64'(rc), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_r0", r0, ExpR0Reset);
    check("reset_r1", r1, ExpR1Reset);
    rst = 1'b0;
    @(negedge clk);

    do_run(5'd12, 12, 8'hF0);
    do_run(5'd6, 6, 8'h96);
    do_run(5'd8, 8, 8'hB4);
    do_run(5'd3, 1, 8'h4B);

    // Stall at ctr=4 for five cycles, then finish.
    rounds_in = 5'd12;
    start     = 1'b1;
    step      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_ctr_pre", 64'(ctr), 64'd4);
    step = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_ctr", 64'(ctr), 64'd4);
      check("stall_rc", 64'(rc), 64'hC3);
    end
    step = 1'b1;
    repeat (8) @(negedge clk);
    check("stall_ctr_end", 64'(ctr), 64'd12);
    @(negedge clk);
    check("stall_done", 64'(done), 64'd1);
    step = 1'b0;
    @(negedge clk);

    // Start pulse mid-run is ignored.
    rounds_in = 5'd12;
    start     = 1'b1;
    step      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ign_ctr7", 64'(ctr), 64'd7);
    rounds_in = 5'd6;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_rounds", 64'(rounds), 64'd12);
    check("ign_ctr8", 64'(ctr), 64'd8);
    repeat (4) @(negedge clk);
    check("ign_ctr12", 64'(ctr), 64'd12);
    @(negedge clk);
    check("ign_done", 64'(done), 64'd1);
    step = 1'b0;
    @(negedge clk);

    // Reset mid-run.
    rounds_in = 5'd12;
    start     = 1'b1;
    step      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ctr5", 64'(ctr), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ctr", 64'(ctr), 64'd0);
    check("rst_mid_rounds", 64'(rounds), 64'd0);
    check("rst_mid_rc", 64'(rc), 64'd0);
    check("rst_mid_valid", 64'(round_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);

    // Reset dominates start/step/seed_load.
    rst       = 1'b1;
    start     = 1'b1;
    step      = 1'b1;
    seed_load = 1'b1;
    seed      = 64'd1;
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    seed_load = 1'b0;
    check("rst_dom_busy", 64'(busy), 64'd0);
    check("rst_dom_r0", r0, ExpR0Reset);
    @(negedge clk);

    // Zero seed reproduces the post-reset state.
    seed_load = 1'b1;
    seed      = 64'd0;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed0_r0", r0, ExpR0Reset);
    check("seed0_r1", r1, ExpR1Reset);
    do_run(5'd12, 12, 8'hF0);

    // seed=1 together with start: first mask is xorshift(1).
    seed_load = 1'b1;
    seed      = 64'd1;
    start     = 1'b1;
    rounds_in = 5'd12;
    step      = 1'b0;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    check("seed1_r0", r0, ExpR0Seed1);
    check("seed1_ctr", 64'(ctr), 64'd1);
    step = 1'b1;
    repeat (12) @(negedge clk);
    check("seed1_done", 64'(done), 64'd1);
    step = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
